demux4x64_router: RTL and testbench

- Registered 1-to-4 distributor for 64-bit words: the inverse of the 4-input select path.
- Accepts one word per cycle on a valid/ready input channel, tagged with a 2-bit destination.
- Delivers each word to one of four output channels. Each channel has its own 1-entry holding register and valid/ready handshake.
- Fans out writeback/response data inside the core (e.g. one producer feeding four consumers) without combinational paths from input to output data.

---
 rtl/demux4x64_router.sv | 89 ++++++++
 tb/tb_demux4x64_router.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/demux4x64_router.sv
// demux4x64_router: registered 1-to-4 distributor for data words.
//
// Accepts one word per cycle on a valid/ready input channel.
// Each word is steered by in_sel into one of four 1-entry holding registers.
// Every holding register has its own valid/ready handshake toward its consumer.
// There is no combinational path from in_data to any output data.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   input handshake; in_ready depends only on in_sel, o_valid, o_ready
//   in_sel           destination channel 0..3
//   in_data          input word
//   o_valid[3:0]     channel k holding register full
//   o_ready[3:0]     consumer k takes its word this cycle
//   O0..O3           holding register contents of channel 0..3
//   cnt0..cnt3       saturating count of words delivered per channel
//   busy             any channel full
module demux4x64_router #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        o_valid,
  input  logic [3:0]        o_ready,
  output logic [DATA_W-1:0] O0,
  output logic [DATA_W-1:0] O1,
  output logic [DATA_W-1:0] O2,
  output logic [DATA_W-1:0] O3,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3,
  output logic              busy
);

  logic [DATA_W-1:0] hold [4];
  logic [CNT_W-1:0]  cnt  [4];
  logic [3:0]        full;
  logic              acc;
  logic [3:0]        load;
  logic [3:0]        drain;

  always_comb begin
    // A full channel can still accept when its consumer drains in the same cycle.
    in_ready = ~full[in_sel] | o_ready[in_sel];
    acc      = in_valid & in_ready;
    load     = acc ? (4'b0001 << in_sel) : 4'b0000;
    drain    = full & o_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        hold[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          full[k] <= 1'b1;
          hold[k] <= in_data;
        end else if (drain[k]) begin
          full[k] <= 1'b0;
        end
        if (drain[k] && (cnt[k] != {CNT_W{1'b1}})) begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign o_valid = full;
  assign busy    = |full;
  assign O0      = hold[0];
  assign O1      = hold[1];
  assign O2      = hold[2];
  assign O3      = hold[3];
  assign cnt0    = cnt[0];
  assign cnt1    = cnt[1];
  assign cnt2    = cnt[2];
  assign cnt3    = cnt[3];

endmodule

// File: tb/tb_demux4x64_router.sv
// tb_demux4x64_router: directed and random stimulus for demux4x64_router.
// A transaction-level model tracks, per channel, whether a word is held, its value,
// and the delivered count. DUT outputs are compared against that model after every edge.
module tb_demux4x64_router;

  localparam int unsigned DW   = 64;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [3:0]    o_valid;
  logic [3:0]    o_ready;
  logic [DW-1:0] O0, O1, O2, O3;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            m_full [4];
  logic [DW-1:0] m_word [4];
  int            m_cnt  [4];

  always #5 clk = ~clk;

  demux4x64_router #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .O0       (O0),
    .O1       (O1),
    .O2       (O2),
    .O3       (O3),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, clock, then check all outputs.
  task automatic step(input bit r, input bit v, input int s, input logic [DW-1:0] d,
                      input logic [3:0] rdy);
    bit            exp_rdy;
    bit            take;
    logic [3:0]    exp_v;
    logic [DW-1:0] dut_o [4];
    int            dut_c [4];
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_sel   = 2'(s);
    in_data  = d;
    o_ready  = rdy;
    #1;
    // A channel takes a new word if it is empty or is being emptied this cycle.
    exp_rdy = !m_full[s] || rdy[s];
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      take = v && exp_rdy;
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && rdy[k]) begin
          if (m_cnt[k] < CMAX) m_cnt[k]++;
          m_full[k] = 1'b0;
        end
      end
      if (take) begin
        m_full[s] = 1'b1;
        m_word[s] = d;
      end
    end
    #1;
    exp_v = {m_full[3], m_full[2], m_full[1], m_full[0]};
    check("o_valid", 64'(o_valid), 64'(exp_v));
    check("busy", 64'(busy), 64'(exp_v != 4'b0000));
    dut_o[0] = O0; dut_o[1] = O1; dut_o[2] = O2; dut_o[3] = O3;
    dut_c[0] = int'(cnt0); dut_c[1] = int'(cnt1); dut_c[2] = int'(cnt2); dut_c[3] = int'(cnt3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("O%0d", k), dut_o[k], m_word[k]);
      check($sformatf("cnt%0d", k), 64'(dut_c[k]), 64'(m_cnt[k]));
    end
  endtask

  initial begin
    int c2_before;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sel   = 2'd0;
    in_data  = '0;
    o_ready  = 4'b0000;
    model_reset();
    step(1, 0, 0, '0, 4'b0000);

    // Reset discards a held word.
    step(0, 1, 2, 64'hDEAD_BEEF, 4'b0000);
    check("pre_reset_O2", O2, 64'hDEAD_BEEF);
    step(1, 0, 0, '0, 4'b0000);
    step(1, 0, 0, '0, 4'b0000);
    check("reset_o_valid", 64'(o_valid), 64'h0);
    check("reset_O2", O2, 64'h0);
    for (int s = 0; s < 4; s++) step(0, 0, s, '0, 4'b0000);

    // Single word held under backpressure; same channel stalls, another accepts.
    step(0, 1, 1, 64'h0123_4567_89AB_CDEF, 4'b0000);
    check("single_o_valid", 64'(o_valid), 64'h2);
    check("single_O1", O1, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 4; i++) step(0, 0, 1, '0, 4'b0000);
    step(0, 1, 1, 64'h5555, 4'b0000);
    check("stall_O1", O1, 64'h0123_4567_89AB_CDEF);
    step(0, 1, 3, 64'h3333, 4'b0000);
    check("other_ch_o_valid", 64'(o_valid), 64'hA);

    // Streaming into channel 0 at full rate.
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 64'(i), 4'b0001);
      check("stream_O0", O0, 64'(i));
    end
    step(0, 0, 0, '0, 4'b0001);
    check("stream_cnt0", 64'(cnt0), 64'd10);

    // Drain and reload in the same cycle.
    step(0, 1, 2, 64'hAA, 4'b0000);
    c2_before = int'(cnt2);
    step(0, 1, 2, 64'hBB, 4'b0100);
    check("reload_O2", O2, 64'hBB);
    check("reload_v2", 64'(o_valid[2]), 64'h1);
    check("reload_cnt2", 64'(cnt2), 64'(c2_before + 1));

    // Saturation of channel 3 counter.
    for (int i = 0; i < 21; i++) step(0, 1, 3, 64'(100 + i), 4'b1000);
    check("sat_cnt3", 64'(cnt3), 64'(CMAX));
    step(0, 0, 0, '0, 4'b1000);
    check("sat_cnt3_hold", 64'(cnt3), 64'(CMAX));

    // Reset mid-operation with all channels full and activity on every port.
    for (int s = 0; s < 4; s++) step(0, 1, s, 64'(16'hF000 + s), 4'b0000);
    check("all_full", 64'(o_valid), 64'hF);
    step(1, 1, 1, 64'hCAFE, 4'b1111);
    check("midrst_o_valid", 64'(o_valid), 64'h0);
    check("midrst_O1", O1, 64'h0);
    check("midrst_cnt1", 64'(cnt1), 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
           {$urandom, $urandom}, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
